// File: rtl/fir_tap_ctrl.sv
// Coefficient-load / delay-line-flush / sample-gating sequencer around a 63-tap FIR.
// Optional coefficient checksum: define FIR_TAP_CTRL_CHKSUM_EN.
module fir_tap_ctrl #(
   parameter int unsigned NTAPS   = 63,
   parameter int unsigned X_W     = 10,
   parameter int unsigned Y_W     = 20,
   parameter int unsigned C_W     = 10,
   parameter int unsigned A_W     = 6,
   parameter int unsigned FIR_LAT = 1
) (
   input  logic           CLK,
   input  logic           RSTN,
   input  logic           cfg_start,
   input  logic           cfg_valid,
   input  logic [C_W-1:0] cfg_data,
   output logic           cfg_ready,
   input  logic [15:0]    cfg_checksum,
   output logic           cfg_err,
   input  logic           in_valid,
   input  logic [X_W-1:0] in_sample,
   output logic           in_ready,
   output logic [X_W-1:0] fir_x,
   output logic           fir_coef_we,
   output logic [A_W-1:0] fir_coef_addr,
   output logic [C_W-1:0] fir_coef_data,
   input  logic [Y_W-1:0] fir_y,
   output logic           out_valid,
   output logic [Y_W-1:0] out_sample,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

   state_t         state;
   logic [A_W-1:0] tap_cnt;
   logic [A_W-1:0] flush_cnt;
   logic           vld_x;
   logic [FIR_LAT:0] vld_dly;
   logic           cfg_acc;
   logic           last_tap;
   logic           chk_ok;

   assign cfg_acc  = cfg_valid & cfg_ready;
   assign last_tap = (tap_cnt == A_W'(NTAPS - 1));

`ifdef FIR_TAP_CTRL_CHKSUM_EN
   logic [15:0] csum;
   logic [15:0] csum_next;
   logic        cfg_err_r;

   assign csum_next = csum + 16'(cfg_data);
   assign chk_ok    = (csum_next == cfg_checksum);
   assign cfg_err   = cfg_err_r;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         csum      <= '0;
         cfg_err_r <= 1'b0;
      end else if (cfg_start) begin
         csum      <= '0;
         cfg_err_r <= 1'b0;
      end else if (state == LOAD && cfg_acc) begin
         csum <= csum_next;
         if (last_tap && !chk_ok)
            cfg_err_r <= 1'b1;
      end
   end
`else
   logic unused_checksum;

   assign unused_checksum = ^cfg_checksum;
   assign chk_ok          = 1'b1;
   assign cfg_err         = 1'b0;
`endif

   // cfg_start takes priority in every state, so a same-cycle word accept is dropped.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state         <= IDLE;
         tap_cnt       <= '0;
         flush_cnt     <= '0;
         fir_x         <= '0;
         fir_coef_we   <= 1'b0;
         fir_coef_addr <= '0;
         fir_coef_data <= '0;
         cfg_ready     <= 1'b0;
         in_ready      <= 1'b0;
         busy          <= 1'b0;
         vld_x         <= 1'b0;
      end else begin
         fir_coef_we <= 1'b0;
         fir_x       <= '0;
         vld_x       <= 1'b0;
         if (cfg_start) begin
            state     <= LOAD;
            tap_cnt   <= '0;
            flush_cnt <= '0;
            cfg_ready <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               LOAD: begin
                  if (cfg_acc) begin
                     fir_coef_we   <= 1'b1;
                     fir_coef_addr <= tap_cnt;
                     fir_coef_data <= cfg_data;
                     if (last_tap) begin
                        tap_cnt   <= '0;
                        cfg_ready <= 1'b0;
                        if (chk_ok) begin
                           state <= FLUSH;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                     end
                  end
               end
               FLUSH: begin
                  if (flush_cnt == A_W'(NTAPS - 1)) begin
                     state     <= RUN;
                     flush_cnt <= '0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                  end else begin
                     flush_cnt <= flush_cnt + 1'b1;
                  end
               end
               RUN: begin
                  if (in_valid && in_ready) begin
                     fir_x <= in_sample;
                     vld_x <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // vld_x is aligned with fir_x; FIR_LAT+1 more stages line it up with out_sample.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         vld_dly <= '0;
      end else if (cfg_start) begin
         vld_dly <= '0;
      end else begin
         vld_dly[0] <= vld_x;
         for (int unsigned i = 1; i <= FIR_LAT; i++)
            vld_dly[i] <= vld_dly[i-1];
      end
   end

   assign out_valid = vld_dly[FIR_LAT];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         out_sample <= '0;
      else
         out_sample <= fir_y;
   end

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Self-checking bench for fir_tap_ctrl; a behavioural FIR stand-in feeds fir_y.
module tb_fir_tap_ctrl;

   localparam int NTAPS   = 63;
   localparam int X_W     = 10;
   localparam int Y_W     = 20;
   localparam int C_W     = 10;
   localparam int A_W     = 6;
   localparam int FIR_LAT = 1;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           cfg_start = 1'b0;
   logic           cfg_valid = 1'b0;
   logic [C_W-1:0] cfg_data = '0;
   logic           cfg_ready;
   logic [15:0]    cfg_checksum = '0;
   logic           cfg_err;
   logic           in_valid = 1'b0;
   logic [X_W-1:0] in_sample = '0;
   logic           in_ready;
   logic [X_W-1:0] fir_x;
   logic           fir_coef_we;
   logic [A_W-1:0] fir_coef_addr;
   logic [C_W-1:0] fir_coef_data;
   logic [Y_W-1:0] fir_y = '0;
   logic           out_valid;
   logic [Y_W-1:0] out_sample;
   logic           busy;

   int errors = 0;
   int checks = 0;
   logic [Y_W-1:0] sb[$];
   logic [Y_W-1:0] exp_y;

   fir_tap_ctrl #(
      .NTAPS(NTAPS), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .A_W(A_W), .FIR_LAT(FIR_LAT)
   ) dut (
      .CLK(clk), .RSTN(rstn),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .cfg_checksum(cfg_checksum), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
      .fir_x(fir_x), .fir_coef_we(fir_coef_we), .fir_coef_addr(fir_coef_addr),
      .fir_coef_data(fir_coef_data), .fir_y(fir_y), .out_valid(out_valid),
      .out_sample(out_sample), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [Y_W-1:0] fmodel(input logic [X_W-1:0] s);
      return Y_W'(s) * 20'd777;
   endfunction

   // FIR stand-in with FIR_LAT = 1
   always @(posedge clk) fir_y <= fmodel(fir_x);

   always @(negedge clk) begin
      if (rstn && out_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected got out_valid=1 sample=%h exp no result pending", out_sample);
         end else begin
            exp_y = sb.pop_front();
            if (out_sample !== exp_y) begin
               errors++;
               $display("FAIL out_sample got=%h exp=%h", out_sample, exp_y);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic start_load(input logic [15:0] csum);
      cfg_start = 1'b1;
      cfg_checksum = csum;
      in_valid = 1'b0;
      @(negedge clk);
      cfg_start = 1'b0;
      sb.delete();
      checks++;
      if (cfg_ready !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL load_entry got rdy=%b busy=%b in_rdy=%b err=%b exp 1 1 0 0",
                  cfg_ready, busy, in_ready, cfg_err);
      end
   endtask

   task automatic feed(input bit stall, input logic [C_W-1:0] fixed, input int count);
      int n = 0;
      int cyc = 0;
      bit acc;
      bit rdy;
      logic [C_W-1:0] exp_d;
      while (n < count && cyc < 4 * count) begin
         cfg_valid = stall ? bit'(cyc % 2) : 1'b1;
         exp_d = (fixed != '0) ? fixed : C_W'(n + 1);
         cfg_data = exp_d;
         acc = cfg_valid;
         rdy = cfg_ready;
         @(negedge clk);
         checks++;
         if (rdy !== 1'b1 ||
             (acc ? (fir_coef_we !== 1'b1 || fir_coef_addr !== A_W'(n) || fir_coef_data !== exp_d)
                  : (fir_coef_we !== 1'b0))) begin
            errors++;
            $display("FAIL coef_write n=%0d got rdy=%b we=%b addr=%0d data=%h exp rdy=1 we=%b addr=%0d data=%h",
                     n, rdy, fir_coef_we, fir_coef_addr, fir_coef_data, acc, n, exp_d);
         end
         if (acc) n++;
         cyc++;
      end
      cfg_valid = 1'b0;
      checks++;
      if (n != count) begin
         errors++;
         $display("FAIL feed_budget got=%0d exp=%0d", n, count);
      end
   endtask

   task automatic check_flush();
      int bad = 0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_drop got=%b exp=0", cfg_ready);
      end
      for (int i = 0; i < NTAPS; i++) begin
         if (busy !== 1'b1 || fir_x !== '0 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL flush_cycles got=%0d bad cycles exp=0", bad);
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL run_entry got in_rdy=%b busy=%b exp 1 0", in_ready, busy);
      end
   endtask

   task automatic drive_sample(input bit v, input logic [X_W-1:0] s);
      in_valid = v;
      in_sample = s;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_run got=%b exp=1", in_ready);
      end
      if (v) sb.push_back(fmodel(s));
      @(negedge clk);
      checks++;
      if (fir_x !== (v ? s : '0)) begin
         errors++;
         $display("FAIL fir_x got=%h exp=%h", fir_x, v ? s : '0);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({fir_x, fir_coef_addr, fir_coef_data, out_sample} !== '0 ||
          {fir_coef_we, cfg_ready, in_ready, out_valid, busy, cfg_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_values got x=%h a=%h d=%h y=%h flags=%b exp all 0", fir_x,
                  fir_coef_addr, fir_coef_data, out_sample,
                  {fir_coef_we, cfg_ready, in_ready, out_valid, busy, cfg_err});
      end
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got in_rdy=%b busy=%b rdy=%b exp 0 0 0", in_ready, busy, cfg_ready);
      end
   endtask

   task automatic test_load();
      start_load(16'h0000);
      feed(1'b0, '0, NTAPS);
      check_flush();
   endtask

   task automatic test_run_latency();
      drive_sample(1'b1, 10'h200);
      in_valid = 1'b0;
      for (int k = 1; k <= FIR_LAT + 3; k++) begin
         checks++;
         if (out_valid !== (k == FIR_LAT + 2)) begin
            errors++;
            $display("FAIL latency T+%0d got out_valid=%b exp=%b", k, out_valid, k == FIR_LAT + 2);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         if (i == 5) cfg_valid = 1'b1;
         drive_sample($urandom_range(0, 3) != 0, X_W'($urandom));
         if (i == 5) begin
            cfg_valid = 1'b0;
            checks++;
            if (fir_coef_we !== 1'b0) begin
               errors++;
               $display("FAIL cfg_outside_load got we=%b exp=0", fir_coef_we);
            end
         end
      end
      in_valid = 1'b0;
      repeat (FIR_LAT + 4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL stream_drain got=%0d pending exp=0", sb.size());
      end
   endtask

   task automatic test_stall();
      start_load(16'h0000);
      feed(1'b1, '0, NTAPS);
      check_flush();
   endtask

   task automatic test_reload();
      for (int i = 0; i < 3; i++) drive_sample(1'b1, X_W'(100 + i));
      start_load(16'h0000);
      feed(1'b0, '0, 30);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data = 10'h155;
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      checks++;
      if (fir_coef_we !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_discard got we=%b rdy=%b exp 0 1", fir_coef_we, cfg_ready);
      end
      feed(1'b0, '0, NTAPS);
      check_flush();
   endtask

   task automatic test_reset_midflush();
      start_load(16'h0000);
      feed(1'b0, '0, NTAPS);
      repeat (10) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({fir_x, fir_coef_addr, fir_coef_data, out_sample} !== '0 ||
          {fir_coef_we, cfg_ready, in_ready, out_valid, busy, cfg_err} !== 6'b0) begin
         errors++;
         $display("FAIL async_reset got x=%h a=%h d=%h y=%h flags=%b exp all 0", fir_x,
                  fir_coef_addr, fir_coef_data, out_sample,
                  {fir_coef_we, cfg_ready, in_ready, out_valid, busy, cfg_err});
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_midreset got in_rdy=%b busy=%b exp 0 0", in_ready, busy);
      end
   endtask

`ifdef FIR_TAP_CTRL_CHKSUM_EN
   task automatic test_chksum();
      int bad = 0;
      start_load(16'hFBC1);
      feed(1'b0, 10'h3FF, NTAPS);
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL chksum_match got err=%b exp=0", cfg_err);
      end
      check_flush();
      start_load(16'hFBC0);
      feed(1'b0, 10'h3FF, NTAPS);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL chksum_mismatch got err=%b busy=%b rdy=%b exp 1 0 0", cfg_err, busy, cfg_ready);
      end
      for (int i = 0; i < NTAPS + 8; i++) begin
         if (in_ready !== 1'b0 || cfg_err !== 1'b1) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL chksum_idle got=%0d bad cycles exp=0", bad);
      end
      start_load(16'h0000);
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_run_latency();
      test_back_to_back();
      test_stall();
      test_reload();
      test_reset_midflush();
`ifdef FIR_TAP_CTRL_CHKSUM_EN
      test_chksum();
`else
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL cfg_err_tied got=%b exp=0", cfg_err);
      end
`endif
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
